// File: rtl/fp_double.sv
// Shared IEEE-754 double-precision types plus the state encodings used by the
// matrix divide sequencer and its iterative divider.
package fp_double;

    typedef logic [63:0] double;

    localparam double       DOUBLE_ZERO = '0;
    localparam int unsigned DBL_BIAS    = 1023;

    typedef enum logic [2:0] {
        MDS_IDLE,
        MDS_ISSUE,
        MDS_WAIT,
        MDS_STORE,
        MDS_DONE
    } mds_state_t;

    typedef enum logic [1:0] {
        DD_NUM,
        DD_ZERO,
        DD_INF,
        DD_NAN
    } dd_kind_t;

endpackage

// File: rtl/double_divide_num.sv
// Iterative IEEE-754 double divider: one quotient bit per cycle, round-to-nearest-even.
// Subnormal operands/results flush to zero; valid is a level held until the next start.
module double_divide_num
    import fp_double::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    input  double dividend,
    input  double divisor,
    output double final_quotient,
    output logic  valid
);

    localparam int unsigned QBITS = 54;

    logic [10:0]        exp_a, exp_b;
    logic [51:0]        frac_a, frac_b;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [52:0]        mant_a, mant_b;
    logic               a_lt_b;
    logic [54:0]        rem_init;
    logic signed [12:0] exp_init;
    dd_kind_t           kind_in;

    logic               busy_q, valid_q, sign_q;
    logic [54:0]        rem_q;
    logic [52:0]        den_q;
    logic [51:0]        quo_q;
    logic [5:0]         cnt_q;
    logic signed [12:0] exp_q;
    dd_kind_t           kind_q;
    double              res_q;

    logic               rem_ge, sticky, round_up;
    logic [54:0]        rem_sub;
    logic [52:0]        frac_sum;
    logic signed [12:0] exp_rnd;
    double              res_d;

    assign exp_a  = dividend[62:52];
    assign exp_b  = divisor[62:52];
    assign frac_a = dividend[51:0];
    assign frac_b = divisor[51:0];
    assign a_zero = (exp_a == '0);
    assign b_zero = (exp_b == '0);
    assign a_inf  = (exp_a == '1) && (frac_a == '0);
    assign b_inf  = (exp_b == '1) && (frac_b == '0);
    assign a_nan  = (exp_a == '1) && (frac_a != '0);
    assign b_nan  = (exp_b == '1) && (frac_b != '0);
    assign mant_a = {1'b1, frac_a};
    assign mant_b = {1'b1, frac_b};
    assign a_lt_b = (mant_a < mant_b);

    // Pre-normalise so the integer quotient bit is always 1.
    assign rem_init = a_lt_b ? {1'b0, mant_a, 1'b0} : {2'b00, mant_a};
    assign exp_init = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b})
                    + $signed(13'(DBL_BIAS)) - (a_lt_b ? 13'sd1 : 13'sd0);

    always_comb begin
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            kind_in = DD_NAN;
        end else if (a_inf || b_zero) begin
            kind_in = DD_INF;
        end else if (a_zero || b_inf) begin
            kind_in = DD_ZERO;
        end else begin
            kind_in = DD_NUM;
        end
    end

    assign rem_ge   = (rem_q >= {2'b00, den_q});
    assign rem_sub  = rem_ge ? (rem_q - {2'b00, den_q}) : rem_q;
    assign sticky   = (rem_sub != '0);
    // Last iteration yields the guard bit; quo_q already holds the fraction.
    assign round_up = rem_ge && (sticky || quo_q[0]);
    assign frac_sum = {1'b0, quo_q} + {52'b0, round_up};
    assign exp_rnd  = exp_q + (frac_sum[52] ? 13'sd1 : 13'sd0);

    always_comb begin
        res_d = {sign_q, 63'b0};
        unique case (kind_q)
            DD_NAN:  res_d = {1'b0, 11'h7FF, 1'b1, 51'b0};
            DD_INF:  res_d = {sign_q, 11'h7FF, 52'b0};
            DD_ZERO: res_d = {sign_q, 63'b0};
            default: begin
                if (exp_rnd > 13'sd2046) begin
                    res_d = {sign_q, 11'h7FF, 52'b0};
                end else if (exp_rnd < 13'sd1) begin
                    res_d = {sign_q, 63'b0};
                end else begin
                    res_d = {sign_q, exp_rnd[10:0], frac_sum[51:0]};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            sign_q  <= 1'b0;
            rem_q   <= '0;
            den_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            kind_q  <= DD_NUM;
            res_q   <= '0;
        end else if (start) begin
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            sign_q  <= dividend[63] ^ divisor[63];
            rem_q   <= rem_init;
            den_q   <= mant_b;
            quo_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= exp_init;
            kind_q  <= kind_in;
        end else if (busy_q) begin
            if (cnt_q == 6'(QBITS - 1)) begin
                busy_q  <= 1'b0;
                valid_q <= 1'b1;
                res_q   <= res_d;
            end else begin
                rem_q <= {rem_sub[53:0], 1'b0};
                quo_q <= {quo_q[50:0], rem_ge};
                cnt_q <= cnt_q + 6'd1;
            end
        end
    end

    assign final_quotient = res_q;
    assign valid          = valid_q;

endmodule

// File: rtl/mat_divide_sched.sv
// Divides every element of a SIZE_A x SIZE_B double matrix by one scalar,
// time-sharing a single double_divide_num in row-major order.
module mat_divide_sched
    import fp_double::*;
#(
    parameter int unsigned SIZE_A  = 8,
    parameter int unsigned SIZE_B  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  double                             scale,
    input  double [SIZE_A-1:0][SIZE_B-1:0]    mat,
    output double [SIZE_A-1:0][SIZE_B-1:0]    mat_out,
    output logic                              valid,
    output logic                              busy,
    output logic                              err
);

    localparam int unsigned RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int unsigned CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    mds_state_t                      state_q, state_d;
    double                           scale_q, scale_d;
    double [SIZE_A-1:0][SIZE_B-1:0]  mat_q, mat_d;
    double [SIZE_A-1:0][SIZE_B-1:0]  res_q, res_d;
    logic                            valid_q, valid_d;
    logic                            err_q, err_d;
    logic [RW-1:0]                   row_q, row_d;
    logic [CW-1:0]                   col_q, col_d;
    logic [TW-1:0]                   tmo_q, tmo_d;

    logic                            div_start, div_valid;
    double                           div_quotient;
    logic                            zero_div, last_elem, tmo_hit;
    logic [TW-1:0]                   tmo_inc;

    assign zero_div  = (scale == DOUBLE_ZERO);
    assign last_elem = (row_q == RW'(SIZE_A - 1)) && (col_q == CW'(SIZE_B - 1));
    assign tmo_inc   = tmo_q + TW'(1);
    assign tmo_hit   = (tmo_inc == TW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MDS_IDLE, MDS_DONE: begin
                if (start) begin
                    state_d = zero_div ? MDS_DONE : MDS_ISSUE;
                end
            end
            MDS_ISSUE: state_d = MDS_WAIT;
            // A result arriving on the timeout cycle still counts.
            MDS_WAIT: begin
                if (div_valid) begin
                    state_d = MDS_STORE;
                end else if (tmo_hit) begin
                    state_d = MDS_DONE;
                end
            end
            MDS_STORE: state_d = last_elem ? MDS_DONE : MDS_ISSUE;
            default:   state_d = MDS_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        div_start = 1'b0;
        unique case (state_q)
            MDS_ISSUE: begin
                busy      = 1'b1;
                div_start = 1'b1;
            end
            MDS_WAIT, MDS_STORE: busy = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        scale_d = scale_q;
        mat_d   = mat_q;
        res_d   = res_q;
        valid_d = valid_q;
        err_d   = err_q;
        row_d   = row_q;
        col_d   = col_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            MDS_IDLE, MDS_DONE: begin
                if (start) begin
                    scale_d = scale;
                    mat_d   = mat;
                    res_d   = '0;
                    valid_d = zero_div;
                    err_d   = zero_div;
                    row_d   = '0;
                    col_d   = '0;
                    tmo_d   = '0;
                end
            end
            MDS_ISSUE: tmo_d = '0;
            MDS_WAIT: begin
                if (!div_valid) begin
                    tmo_d = tmo_inc;
                    if (tmo_hit) begin
                        err_d   = 1'b1;
                        valid_d = 1'b1;
                    end
                end
            end
            MDS_STORE: begin
                res_d[row_q][col_q] = div_quotient;
                if (last_elem) begin
                    valid_d = 1'b1;
                end else if (col_q == CW'(SIZE_B - 1)) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale_q <= '0;
            mat_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            tmo_q   <= '0;
        end else begin
            scale_q <= scale_d;
            mat_q   <= mat_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tmo_q   <= tmo_d;
        end
    end

    double_divide_num u_div (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (div_start),
        .dividend       (mat_q[row_q][col_q]),
        .divisor        (scale_q),
        .final_quotient (div_quotient),
        .valid          (div_valid)
    );

    assign mat_out = res_q;
    assign valid   = valid_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mat_divide_sched.sv
// Scoreboard bench for mat_divide_sched: results checked against real-valued division,
// plus a short-timeout instance exercising the abort path.
module tb_mat_divide_sched;
    import fp_double::*;

    localparam int unsigned SA      = 2;
    localparam int unsigned SB      = 3;
    localparam int unsigned NEL     = SA * SB;
    localparam int unsigned DIV_LAT = 55;   // divider: load edge plus 54 quotient-bit edges
    localparam int unsigned OP_CYC  = 1 + NEL * (DIV_LAT + 2);
    localparam int unsigned T_TMO   = 10;

    typedef double [SA-1:0][SB-1:0] mat_t;
    typedef double [1:0][1:0]       tmat_t;

    typedef struct {
        mat_t        q;
        logic        err;
        int unsigned lat;
        int unsigned t0;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  start;
    double scale;
    mat_t  mat, mat_out;
    logic  valid, busy, err;

    logic  t_start;
    double t_scale;
    tmat_t t_mat, t_mat_out;
    logic  t_valid, t_busy, t_err;

    exp_t        sb_q[$];
    int unsigned cyc    = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    mat_divide_sched #(.SIZE_A(SA), .SIZE_B(SB), .TIMEOUT(255)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .scale(scale), .mat(mat),
        .mat_out(mat_out), .valid(valid), .busy(busy), .err(err)
    );

    mat_divide_sched #(.SIZE_A(2), .SIZE_B(2), .TIMEOUT(T_TMO)) u_tmo (
        .clk(clk), .rst_n(rst_n), .start(t_start), .scale(t_scale), .mat(t_mat),
        .mat_out(t_mat_out), .valid(t_valid), .busy(t_busy), .err(t_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    function automatic double rand_double(input int unsigned lo, input int unsigned hi);
        logic [63:0] raw;
        raw = {$urandom, $urandom};
        return {1'($urandom_range(0, 1)), 11'($urandom_range(lo, hi)), raw[51:0]};
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int unsigned r = 0; r < SA; r++)
            for (int unsigned c = 0; c < SB; c++)
                m[r][c] = rand_double(990, 1060);
        return m;
    endfunction

    // Reference: every element divided by the scalar using real arithmetic.
    function automatic exp_t model(input mat_t m, input double s, input int unsigned t0);
        exp_t e;
        e.t0 = t0;
        e.q  = '0;
        if (s == 64'h0) begin
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            for (int unsigned r = 0; r < SA; r++)
                for (int unsigned c = 0; c < SB; c++)
                    e.q[r][c] = $realtobits($bitstoreal(m[r][c]) / $bitstoreal(s));
            e.err = 1'b0;
            e.lat = OP_CYC;
        end
        return e;
    endfunction

    task automatic issue(input mat_t m, input double s, input bit track);
        @(posedge clk); #1;
        mat   = m;
        scale = s;
        start = 1'b1;
        if (track) sb_q.push_back(model(m, s, cyc));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("pending_results", sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Monitor: each rising valid retires one expected result.
    initial begin
        logic vprev;
        exp_t e;
        vprev = 1'b0;
        forever begin
            @(negedge clk);
            if (valid && !vprev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid=1 expected no pending result");
                end else begin
                    e = sb_q.pop_front();
                    for (int unsigned r = 0; r < SA; r++)
                        for (int unsigned c = 0; c < SB; c++)
                            chk($sformatf("mat_out[%0d][%0d]", r, c), mat_out[r][c], e.q[r][c]);
                    chk("err", err, e.err);
                    chk("valid_latency", cyc - e.t0, e.lat);
                end
            end
            vprev = valid;
        end
    end

    initial begin
        mat_t        m, mb;
        tmat_t       tm;
        double       s;
        int unsigned t0, n;

        rst_n   = 1'b0;
        start   = 1'b0;
        scale   = '0;
        mat     = '0;
        t_start = 1'b0;
        t_scale = '0;
        t_mat   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);
        for (int unsigned r = 0; r < SA; r++)
            for (int unsigned c = 0; c < SB; c++)
                chk($sformatf("reset_mat_out[%0d][%0d]", r, c), mat_out[r][c], 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero divisor: immediate err/valid, no elements computed.
        issue(rand_mat(), 64'h0, 1'b1);
        chk("zero_scale_busy", busy, 0);
        wait_drain(20);

        // Directed: {2,4,6;8,10,12} / 2.0
        for (int unsigned r = 0; r < SA; r++)
            for (int unsigned c = 0; c < SB; c++)
                m[r][c] = $realtobits(2.0 * (r * SB + c + 1));
        issue(m, $realtobits(2.0), 1'b1);
        wait_drain(OP_CYC + 20);

        for (int k = 0; k < 4; k++) begin
            issue(rand_mat(), rand_double(1000, 1046), 1'b1);
            wait_drain(OP_CYC + 20);
        end

        // Stray start mid-operation must be ignored.
        m  = rand_mat();
        s  = rand_double(1000, 1046);
        mb = rand_mat();
        issue(m, s, 1'b1);
        repeat (100) @(posedge clk);
        #1;
        chk("busy_mid_op", busy, 1);
        issue(mb, $realtobits(3.0), 1'b0);
        wait_drain(OP_CYC + 20);

        // Start from DONE: valid drops on the sampling edge.
        issue(mb, $realtobits(3.0), 1'b1);
        chk("restart_valid_drop", valid, 0);
        chk("restart_busy", busy, 1);
        wait_drain(OP_CYC + 20);

        // Reset asserted during WAIT of the third element.
        issue(rand_mat(), rand_double(1000, 1046), 1'b1);
        repeat (2 * (DIV_LAT + 2) + 20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        for (int unsigned r = 0; r < SA; r++)
            for (int unsigned c = 0; c < SB; c++)
                chk($sformatf("midrst_mat_out[%0d][%0d]", r, c), mat_out[r][c], 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(rand_mat(), rand_double(1000, 1046), 1'b1);
        wait_drain(OP_CYC + 20);

        // Timeout instance: divider latency exceeds TIMEOUT.
        for (int unsigned r = 0; r < 2; r++)
            for (int unsigned c = 0; c < 2; c++)
                tm[r][c] = rand_double(990, 1060);
        @(posedge clk); #1;
        t_mat   = tm;
        t_scale = $realtobits(3.0);
        t_start = 1'b1;
        t0      = cyc;
        @(posedge clk); #1;
        t_start = 1'b0;
        chk("tmo_busy_running", t_busy, 1);
        n = 0;
        while (!t_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency", cyc - t0, 2 + T_TMO);
        chk("tmo_err", t_err, 1);
        chk("tmo_busy_fall", t_busy, 0);
        for (int unsigned r = 0; r < 2; r++)
            for (int unsigned c = 0; c < 2; c++)
                chk($sformatf("tmo_mat_out[%0d][%0d]", r, c), t_mat_out[r][c], 0);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mat_divide_sched.md
# mat_divide_sched

Sequencing controller that time-shares a single `double_divide_num` instance across every element of a `SIZE_A x SIZE_B` matrix of `fp_double::double` values, dividing each by one common scalar. It replaces the fully parallel per-element divider array where area matters more than latency, such as normalisation stages of the fetal-ECG matrix pipeline. It latches the operands on `start`, issues one division at a time in row-major order and presents the full result matrix with a level `valid`.

## Interface
Parameters:
- `SIZE_A`, 8, matrix rows.
- `SIZE_B`, 8, matrix columns.
- `TIMEOUT`, 255, maximum cycles spent waiting for one divider result before aborting.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `scale`  in  double  divisor, latched on accepted `start`.
- `mat`  in  double[SIZE_A][SIZE_B]  dividends, latched on accepted `start`.
- `mat_out`  out  double[SIZE_A][SIZE_B]  quotients.
- `valid`  out  1  result matrix complete and stable.
- `busy`  out  1  operation in progress.
- `err`  out  1  divide-by-zero or divider timeout on the last operation.

## Operation
- FSM states: IDLE, ISSUE, WAIT, STORE, DONE.
- IDLE/DONE + `start`=1: latch `scale`, `mat`; clear `mat_out`, `valid`, `err`; reset the element index to (0,0).
  - If `scale` is the all-zero bit pattern: set `err`=1 and `valid`=1, go to DONE. `mat_out` stays all zero and the divider is not started.
  - Otherwise go to ISSUE.
- ISSUE: drive `div_start`=1 for exactly one cycle, with the dividend set to the latched `mat[r][c]` and the divisor set to the latched `scale`. Go to WAIT. Operands stay stable until STORE.
- WAIT: `div_start`=0 and the timeout counter increments each cycle.
  - On the first cycle `div_valid`=1, go to STORE.
  - If the counter reaches `TIMEOUT`: `err`=1, `valid`=1, go to DONE. Elements not yet stored remain zero.
- STORE: write the quotient into `mat_out[r][c]`.
  - If this is the last element (SIZE_A-1, SIZE_B-1): `valid`=1, go to DONE.
  - Else advance the index: c+1, wrapping c to 0 and incrementing r. Go to ISSUE.
  - The one-cycle gap before the next ISSUE re-arms level-valid dividers.
- DONE: hold `mat_out`, `valid`, `err` until the next accepted `start`.
- `start` during ISSUE/WAIT/STORE is ignored, with no queuing.
- `busy`=1 in ISSUE, WAIT and STORE only.
- Index widths: `$clog2(SIZE_A)` and `$clog2(SIZE_B)` bits, minimum 1. The timeout counter is `$clog2(TIMEOUT+1)` bits.

## Timing
- Reset values: `mat_out` all zero, `valid`=0, `busy`=0, `err`=0, state IDLE, divider start 0. Reset asserted mid-operation aborts immediately; the divider is simply re-started on the next operation.
- Divider latency L is measured in cycles from the `div_start` cycle to the `div_valid` cycle, L≥1.
- Per element: 1 (ISSUE) + L (WAIT) + 1 (STORE) cycles.
- `start` at edge 0 gives `valid`=1 after edge 1+N·(L+2), where N=SIZE_A·SIZE_B.
- Zero divisor gives `valid`=1 after edge 1.
- `start` in DONE: `valid` falls on the next edge and the new operation begins (back-to-back capable).
- `start` and a timeout in the same cycle: the timeout wins, and `start` is ignored because the state is WAIT.

## Structure
- `double`, and the zero constant `DOUBLE_ZERO`, come from the shared `fp_double` package. Add a state enum `mds_state_t` to the same package.
- The one sub-module is an existing `double_divide_num` instance, with `start`, `dividend`, `divisor`, `final_quotient` and `valid` driven by the FSM.
- FSM, index counters, timeout counter and result registers are all in the top module.

## Test plan
- Run `SIZE_A`=`SIZE_B`=2 with `mat` = {2.0, 4.0; 6.0, 8.0} and `scale`=2.0. Required: `mat_out` = {1.0, 2.0; 3.0, 4.0}, and `valid` rises exactly 1+4·(L+2) cycles after `start`.
- Replace the divider with a stub of fixed L=5 on a 3x3 matrix. Required: `div_start` pulses 9 times, spaced 7 cycles apart, issued in row-major order, and `valid` rises at cycle 64.
- Drive `scale`=+0.0. Required: `err`=1 and `valid`=1 one cycle after `start`, `mat_out` all zero, and no `div_start` pulse.
- Use a stub divider that never asserts valid, with `TIMEOUT`=10. Required: `err`=1 and `valid`=1 after 1+1+10 cycles, and `busy` falls.
- Pulse `start` again mid-operation with different data. Required: it is ignored and the results match the first data set. Then assert `start` in DONE. Required: `valid` drops on the next edge and the second result appears.
- Assert `rst_n`=0 during WAIT of element 2. Required: all outputs go to zero asynchronously. After release, a fresh operation completes correctly.
